// File: rtl/plic_lite_if.sv
// Data-memory bus slice seen by plic_lite: one-cycle read/write strobes,
// byte address, write data and registered read data.
interface plic_lite_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_ren, output mem_wen, output mem_addr,
                  output mem_wdata, input mem_rdata);
  modport slave  (input mem_ren, input mem_wen, input mem_addr,
                  input mem_wdata, output mem_rdata);
endinterface

// File: rtl/plic_lite.sv
// plic_lite: memory-mapped external-interrupt controller.
// NUM_SRC sources (IDs 1..NUM_SRC, 0 = none), per-source priority, global
// threshold, claim/complete handshake, registered external_interrupt.
// Optional macro PLIC_EDGE_TRIG_EN: rising-edge gateways with a one-deep
// "again" flag per source; default build is level-sensitive.
module plic_lite #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  plic_lite_if.slave         bus,
  output logic               external_interrupt
);

  localparam int IDW = 5;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_CLAIM = 2'd2} gw_state_e;

  logic [NUM_SRC-1:0] r_sync1, r_sync2;
`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] r_sync3;
`endif
  logic [NUM_SRC-1:0] r_en;
  logic [PRIO_W-1:0]  r_thresh;
  logic [PRIO_W-1:0]  r_prio [NUM_SRC];
  logic [31:0]        r_rdata;
  logic               r_ext;

  logic [NUM_SRC-1:0] w_pend;
  logic [5:0]         w_word;
  logic               w_claim_rd, w_cmpl_wr;
  logic [IDW-1:0]     w_cmpl_id;
  logic [IDW-1:0]     w_win_id;
  logic [PRIO_W-1:0]  w_win_prio;
  logic               w_win_vld, w_win_ok;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_word     = bus.mem_addr[7:2];
  assign w_claim_rd = bus.mem_ren && (w_word == 6'd3);
  assign w_cmpl_wr  = bus.mem_wen && (w_word == 6'd3);
  assign w_cmpl_id  = bus.mem_wdata[IDW-1:0];
  assign w_unused   = ^{bus.mem_addr[1:0], bus.mem_wdata};

  assign bus.mem_rdata     = r_rdata;
  assign external_interrupt = r_ext;

  // Two-flop synchronizer on every source line (plus history flop in edge mode)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
`ifdef PLIC_EDGE_TRIG_EN
      r_sync3 <= '0;
`endif
    end else begin
      r_sync1 <= src_irq;
      r_sync2 <= r_sync1;
`ifdef PLIC_EDGE_TRIG_EN
      r_sync3 <= r_sync2;
`endif
    end
  end

  // Arbitration: highest priority among eligible sources, ascending scan with
  // strict compare so ties resolve to the lowest ID; priority 0 never wins.
  always_comb begin
    w_win_id   = '0;
    w_win_prio = '0;
    w_win_vld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pend[i] && r_en[i] && (r_prio[i] > w_win_prio)) begin
        w_win_prio = r_prio[i];
        w_win_id   = IDW'(i + 1);
        w_win_vld  = 1'b1;
      end
    end
    w_win_ok = w_win_vld && (w_win_prio > r_thresh);
  end

  // Per-source gateways
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    gw_state_e r_state;
    logic      w_claim, w_cmpl, w_trig;

    assign w_claim = w_claim_rd && w_win_ok && (w_win_id == IDW'(g + 1));
    assign w_cmpl  = w_cmpl_wr && (w_cmpl_id == IDW'(g + 1));
    assign w_pend[g] = (r_state == S_PEND);

`ifdef PLIC_EDGE_TRIG_EN
    logic r_again;
    assign w_trig = r_sync2[g] & ~r_sync3[g];

    // Edge gateway: edges in PEND are absorbed, an edge in CLAIM is remembered
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_again <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:  if (w_trig) r_state <= S_PEND;
          S_PEND:  if (w_claim) r_state <= S_CLAIM;
          S_CLAIM: begin
            if (w_cmpl) begin
              r_state <= (r_again || w_trig) ? S_PEND : S_IDLE;
              r_again <= 1'b0;
            end else if (w_trig) begin
              r_again <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
`else
    assign w_trig = r_sync2[g];

    // Level gateway: a completed source still high re-pends via IDLE next cycle
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (w_trig) r_state <= S_PEND;
          S_PEND:  if (w_claim) r_state <= S_CLAIM;
          S_CLAIM: if (w_cmpl) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
`endif
  end

  // Read mux over the register map; unmapped words read 0
  always_comb begin
    w_rdata = '0;
    case (w_word)
      6'd0: w_rdata = 32'({w_pend, 1'b0});
      6'd1: w_rdata = 32'({r_en, 1'b0});
      6'd2: w_rdata = 32'(r_thresh);
      6'd3: w_rdata = w_win_ok ? 32'(w_win_id) : 32'd0;
      default: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (w_word == 6'(i + 4)) w_rdata = 32'(r_prio[i]);
      end
    endcase
  end

  // Configuration registers; a same-cycle read sees pre-write contents
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_en     <= '0;
      r_thresh <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_prio[i] <= '0;
    end else if (bus.mem_wen) begin
      if (w_word == 6'd1) r_en     <= bus.mem_wdata[NUM_SRC:1];
      if (w_word == 6'd2) r_thresh <= bus.mem_wdata[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++)
        if (w_word == 6'(i + 4)) r_prio[i] <= bus.mem_wdata[PRIO_W-1:0];
    end
  end

  // Registered read data (held until next read) and interrupt level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_ext   <= 1'b0;
    end else begin
      if (bus.mem_ren) r_rdata <= w_rdata;
      r_ext <= w_win_ok;
    end
  end

endmodule
